// File: rtl/data_frame_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_frame_pkg : shared types for the data_frame_marker framer
// Rev 1.0
// ---------------------------------------------------------------------------
package data_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } frame_state_e;

endpackage
`default_nettype wire

// File: rtl/data_frame_marker_idle_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// idle_timer : counts idle cycles, flags expiry on the limit-th idle cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module idle_timer #(
  parameter int TSIZE = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             run,
  input  logic [TSIZE-1:0] limit,
  output logic             expire
);

  logic [TSIZE-1:0] count_q;
  logic [TSIZE-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && (count_q != {TSIZE{1'b1}})) begin
      count_d = count_q + TSIZE'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds idle cycles already elapsed, so this idle cycle is number count_q+1
  assign expire = run && (limit != '0) && (count_q == (limit - TSIZE'(1)));

endmodule
`default_nettype wire

// File: rtl/data_frame_marker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_frame_marker : adds last/mark flags to a raw beat stream for the AXIS bridge
// Rev 1.0
// ---------------------------------------------------------------------------
module data_frame_marker
  import data_frame_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int LSIZE = 24,
  parameter int TSIZE = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [LSIZE-1:0] frame_len,
  input  logic [TSIZE-1:0] idle_timeout,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  output logic             out_last,
  output logic             out_mark,
  input  logic             out_ready,
  output logic             frame_open
);

  frame_state_e     state_q, state_d;
  logic [LSIZE-1:0] len_q, len_d;
  logic [LSIZE-1:0] beat_cnt_q, beat_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [DSIZE-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_mark_q, out_mark_d;
  logic             frame_open_q, frame_open_d;

  logic             out_free;
  logic             accept;
  logic             timer_clear;
  logic             timer_run;
  logic             timer_expire;
  logic [LSIZE-1:0] first_len;
  logic [LSIZE-1:0] next_cnt;
  logic             beat_last;

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = (state_q != CLOSE) && out_free;
  assign accept    = in_valid && in_ready;
  assign first_len = (frame_len == '0) ? LSIZE'(1) : frame_len;
  assign next_cnt  = beat_cnt_q + LSIZE'(1);

  assign timer_run   = (state_q == OPEN) && !accept;
  assign timer_clear = (state_q != OPEN) || accept;

  idle_timer #(
    .TSIZE (TSIZE)
  ) u_idle_timer (
    .clock  (clock),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .run    (timer_run),
    .limit  (idle_timeout),
    .expire (timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_mark_d   = out_mark_q;
    frame_open_d = frame_open_q;
    beat_last    = 1'b0;

    // Retire the current beat first so a new load in the same cycle overrides it
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      if (out_last_q) begin
        frame_open_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          len_d      = first_len;
          beat_cnt_d = LSIZE'(1);
          beat_last  = (first_len == LSIZE'(1));
          state_d    = beat_last ? IDLE : OPEN;
        end
      end
      OPEN: begin
        if (accept) begin
          beat_cnt_d = next_cnt;
          beat_last  = (next_cnt == len_q) || flush;
          if (beat_last) begin
            state_d = IDLE;
          end
        end else if (flush || timer_expire) begin
          state_d = CLOSE;
        end
      end
      CLOSE: begin
        if (out_free) begin
          out_valid_d  = 1'b1;
          out_data_d   = '0;
          out_last_d   = 1'b1;
          out_mark_d   = 1'b1;
          frame_open_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = in_data;
      out_last_d   = beat_last;
      out_mark_d   = 1'b0;
      frame_open_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_mark_q   <= 1'b0;
      frame_open_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_mark_q   <= out_mark_d;
      frame_open_q <= frame_open_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign out_mark   = out_mark_q;
  assign frame_open = frame_open_q;

endmodule
`default_nettype wire

// File: tb/tb_data_frame_marker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_data_frame_marker : scoreboard bench for data_frame_marker
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_data_frame_marker;

  localparam int DSIZE = 32;
  localparam int LSIZE = 24;
  localparam int TSIZE = 16;

  typedef struct {
    logic [DSIZE-1:0] data;
    logic             last;
    logic             mark;
  } exp_t;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic [LSIZE-1:0] frame_len = '0;
  logic [TSIZE-1:0] idle_timeout = '0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [DSIZE-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [DSIZE-1:0] out_data;
  logic             out_last;
  logic             out_mark;
  logic             out_ready = 1'b1;
  logic             frame_open;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  int   m_cnt = 0;
  int   m_len = 1;
  logic rand_en = 1'b0;
  int   cyc = 0;
  int   last_data_cyc = 0;
  int   last_mark_cyc = 0;
  logic prev_stall = 1'b0;
  logic [DSIZE+2:0] prev_out = '0;

  data_frame_marker #(
    .DSIZE (DSIZE),
    .LSIZE (LSIZE),
    .TSIZE (TSIZE)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .frame_len    (frame_len),
    .idle_timeout (idle_timeout),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_mark     (out_mark),
    .out_ready    (out_ready),
    .frame_open   (frame_open)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // out_ready changes just after the active edge so it is settled at both sample points
  always @(posedge clock) begin
    #1;
    out_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor / scoreboard pop
  always @(negedge clock) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold", 64'({out_valid, out_data, out_last, out_mark}), 64'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          chk("out_last", 64'(out_last), 64'(e.last));
          chk("out_mark", 64'(out_mark), 64'(e.mark));
          if (!e.mark) begin
            chk("out_data", 64'(out_data), 64'(e.data));
            last_data_cyc = cyc;
          end else begin
            last_mark_cyc = cyc;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, out_data, out_last, out_mark};
    end
  end

  // Drive one beat from a negedge; acceptance is judged just before the edge
  task automatic send(input logic [DSIZE-1:0] d, input logic f);
    logic acc;
    logic done;
    int   prev;
    exp_t e;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    flush    = f;
    for (int i = 0; i < 200 && !done; i++) begin
      #4;
      acc = in_ready;
      @(posedge clock);
      if (acc) begin
        prev = m_cnt;
        if (prev == 0) begin
          m_len = (frame_len == '0) ? 1 : int'(frame_len);
          m_cnt = 1;
        end else begin
          m_cnt = m_cnt + 1;
        end
        e.data = d;
        e.mark = 1'b0;
        e.last = (m_cnt == m_len) || (f && prev != 0);
        if (e.last) m_cnt = 0;
        q.push_back(e);
        done = 1'b1;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    if (!done) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic expect_marker();
    exp_t e;
    e.data = '0;
    e.last = 1'b1;
    e.mark = 1'b1;
    q.push_back(e);
    m_cnt = 0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clock);
    chk(tag, 64'(q.size()), 64'(0));
    @(negedge clock);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    repeat (3) @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_mark", 64'(out_mark), 64'(0));
    chk("rst_frame_open", 64'(frame_open), 64'(0));
    rst_n = 1'b1;
    @(negedge clock);

    // 1: fixed length 4, back-to-back
    frame_len = 24'd4;
    for (int i = 0; i < 8; i++) send(32'h1000 + 32'(i), 1'b0);
    drain("t1_drain");
    chk("t1_frame_closed", 64'(frame_open), 64'(0));

    // 2: length 0 behaves as 1
    frame_len = 24'd0;
    for (int i = 0; i < 3; i++) send(32'h2000 + 32'(i), 1'b0);
    drain("t2_drain");

    // 3: idle timeout closes the frame with a marker
    frame_len    = 24'd8;
    idle_timeout = 16'd10;
    for (int i = 0; i < 3; i++) send(32'h3000 + 32'(i), 1'b0);
    expect_marker();
    drain("t3_drain");
    gap = last_mark_cyc - last_data_cyc;
    chk("t3_timeout_gap_in_10_12", 64'((gap >= 10) && (gap <= 12)), 64'(1));
    idle_timeout = 16'd0;

    // 4: flush together with beat 3 makes it the last beat, no marker
    frame_len = 24'd8;
    send(32'h4000, 1'b0);
    send(32'h4001, 1'b0);
    send(32'h4002, 1'b1);
    repeat (20) @(negedge clock);
    drain("t4_drain");
    chk("t4_frame_closed", 64'(frame_open), 64'(0));

    // 5: flush in IDLE ignored; disabled timeout never closes
    pulse_flush();
    repeat (10) @(negedge clock);
    send(32'h5000, 1'b0);
    repeat (1000) @(negedge clock);
    chk("t5_no_extra_beats", 64'(q.size()), 64'(0));
    chk("t5_frame_open", 64'(frame_open), 64'(1));
    pulse_flush();
    expect_marker();
    drain("t5_drain");
    chk("t5_frame_closed", 64'(frame_open), 64'(0));

    // 6: random backpressure, length 5
    rand_en   = 1'b1;
    frame_len = 24'd5;
    for (int i = 0; i < 20; i++) send(32'h6000 + 32'(i), 1'b0);
    drain("t6_drain");
    rand_en = 1'b0;
    repeat (3) @(negedge clock);

    // 7: async reset mid-frame, then a fresh frame ignoring a mid-frame length change
    frame_len = 24'd4;
    send(32'h7000, 1'b0);
    send(32'h7001, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_out_valid", 64'(out_valid), 64'(0));
    chk("t7_rst_out_last", 64'(out_last), 64'(0));
    chk("t7_rst_frame_open", 64'(frame_open), 64'(0));
    q.delete();
    m_cnt = 0;
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    send(32'h7100, 1'b0);
    frame_len = 24'd2;
    send(32'h7101, 1'b0);
    send(32'h7102, 1'b0);
    send(32'h7103, 1'b0);
    drain("t7_drain");
    chk("t7_frame_closed", 64'(frame_open), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
